l2_cache: RTL and testbench

- Direct-mapped, write-through, no-write-allocate L2 that sits directly downstream of dcache.
- Consumes dcache's word-granular L2 request port (l1_* side below) and refills lines from a backing memory over a word-granular request/fulfil port (mem_* side).
- Pairs with dcache in integration benches, replacing the combinational golden-memory responder.
- Uses xentry_pkg memory_operation_e (LOAD, STORE).

---
 rtl/l2_cache.sv | 153 +++++++++++++++
 tb/tb_l2_cache.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_cache.sv
// Direct-mapped, write-through, no-write-allocate L2 behind dcache.
// Misses refill the whole line one word at a time from backing memory.
package xentry_pkg;
  typedef enum logic {LOAD = 1'b0, STORE = 1'b1} memory_operation_e;
endpackage

module l2_cache
  import xentry_pkg::*;
#(
  parameter int LINE_SIZE  = 16,
  parameter int CACHE_SIZE = 1024,
  parameter int XLEN       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   l1_req_address,
  input  memory_operation_e l1_req_type,
  input  logic              l1_req_valid,
  input  logic [XLEN-1:0]   l1_word_to_store,
  output logic [XLEN-1:0]   l1_fetched_word,
  output logic              l1_fetched_word_valid,
  output logic [XLEN-1:0]   mem_req_address,
  output memory_operation_e mem_req_type,
  output logic              mem_req_valid,
  output logic [XLEN-1:0]   mem_word_to_store,
  input  logic [XLEN-1:0]   mem_fetched_word,
  input  logic              mem_req_fulfilled,
  output logic [2:0]        debug_state
);
  localparam int WPL      = LINE_SIZE / 4;
  localparam int NLINES   = CACHE_SIZE / LINE_SIZE;
  localparam int OFF_BITS = $clog2(WPL);
  localparam int IDX_BITS = $clog2(NLINES);
  localparam int CW       = (OFF_BITS > 0) ? OFF_BITS : 1;
  localparam int IW       = (IDX_BITS > 0) ? IDX_BITS : 1;
  localparam int IDX_LSB  = 2 + OFF_BITS;
  localparam int TAG_LSB  = IDX_LSB + IDX_BITS;
  localparam int TW       = XLEN - TAG_LSB;

  typedef enum logic [2:0] {IDLE, LOOKUP, FILL, STORE_THRU, RESPOND} state_e;

  state_e            state;
  logic [XLEN-1:0]   req_addr;
  memory_operation_e req_type;
  logic [XLEN-1:0]   req_word;
  logic [CW-1:0]     count;
  logic [NLINES-1:0] valid_bits;
  logic [TW-1:0]     tag_mem  [NLINES];
  logic [XLEN-1:0]   data_mem [NLINES][WPL];

  logic [CW-1:0]   req_off;
  logic [IW-1:0]   req_idx;
  logic [TW-1:0]   req_tag;
  logic            hit;
  logic [XLEN-1:0] line_base;
  logic [XLEN-1:0] rd_word;

  // Masking keeps the split correct when a field collapses to zero bits.
  always_comb begin
    req_off   = CW'((req_addr >> 2) & XLEN'(WPL - 1));
    req_idx   = IW'((req_addr >> IDX_LSB) & XLEN'(NLINES - 1));
    req_tag   = TW'(req_addr >> TAG_LSB);
    hit       = valid_bits[req_idx] && (tag_mem[req_idx] == req_tag);
    line_base = (XLEN'(req_tag) << TAG_LSB) | (XLEN'(req_idx) << IDX_LSB);
    rd_word   = data_mem[req_idx][req_off];
  end

  assign debug_state = state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state                 <= IDLE;
      valid_bits            <= '0;
      count                 <= '0;
      req_addr              <= '0;
      req_type              <= LOAD;
      req_word              <= '0;
      l1_fetched_word       <= '0;
      l1_fetched_word_valid <= 1'b0;
      mem_req_address       <= '0;
      mem_req_type          <= LOAD;
      mem_req_valid         <= 1'b0;
      mem_word_to_store     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (l1_req_valid) begin
            req_addr <= l1_req_address;
            req_type <= l1_req_type;
            req_word <= l1_word_to_store;
            state    <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (req_type == LOAD) begin
            if (hit) begin
              l1_fetched_word       <= rd_word;
              l1_fetched_word_valid <= 1'b1;
              state                 <= RESPOND;
            end else begin
              valid_bits[req_idx] <= 1'b0;
              tag_mem[req_idx]    <= req_tag;
              count               <= '0;
              state               <= FILL;
            end
          end else begin
            if (hit) data_mem[req_idx][req_off] <= req_word;
            state <= STORE_THRU;
          end
        end
        // Request is raised from a low cycle, so valid drops once between words.
        FILL: begin
          if (!mem_req_valid) begin
            mem_req_valid   <= 1'b1;
            mem_req_type    <= LOAD;
            mem_req_address <= line_base | (XLEN'(count) << 2);
          end else if (mem_req_fulfilled) begin
            mem_req_valid            <= 1'b0;
            data_mem[req_idx][count] <= mem_fetched_word;
            count                    <= count + CW'(1);
            if (count == CW'(WPL - 1)) begin
              valid_bits[req_idx] <= 1'b1;
              state               <= RESPOND;
            end
          end
        end
        STORE_THRU: begin
          if (!mem_req_valid) begin
            mem_req_valid     <= 1'b1;
            mem_req_type      <= STORE;
            mem_req_address   <= {req_addr[XLEN-1:2], 2'b00};
            mem_word_to_store <= req_word;
          end else if (mem_req_fulfilled) begin
            mem_req_valid <= 1'b0;
            state         <= RESPOND;
          end
        end
        // After a fill, completion is raised here from the freshly written line.
        RESPOND: begin
          if (l1_fetched_word_valid && !l1_req_valid) begin
            l1_fetched_word_valid <= 1'b0;
            l1_fetched_word       <= '0;
            state                 <= IDLE;
          end else begin
            l1_fetched_word_valid <= 1'b1;
            l1_fetched_word       <= (req_type == LOAD) ? rd_word : '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_l2_cache.sv
// Directed bench for l2_cache: a latency-L backing memory model logs every
// memory transaction; each scenario task checks its own results inline.
`timescale 1ns/1ps
module tb_l2_cache;
  import xentry_pkg::*;

  localparam int MEM_L   = 3;
  localparam int TIMEOUT = 200;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       l1_req_address;
  memory_operation_e l1_req_type;
  logic              l1_req_valid;
  logic [31:0]       l1_word_to_store;
  logic [31:0]       l1_fetched_word;
  logic              l1_fetched_word_valid;
  logic [31:0]       mem_req_address;
  memory_operation_e mem_req_type;
  logic              mem_req_valid;
  logic [31:0]       mem_word_to_store;
  logic [31:0]       mem_fetched_word = '0;
  logic              mem_ack = 1'b0;
  logic              spur_ack;
  logic [2:0]        debug_state;

  int checks = 0;
  int failures = 0;
  int mem_wait = 0;

  logic [31:0]       mem_addr_q[$];
  logic [31:0]       mem_data_q[$];
  memory_operation_e mem_type_q[$];
  logic [31:0]       mem_store[logic [31:0]];

  l2_cache dut (
    .clk                   (clk),
    .reset                 (reset),
    .l1_req_address        (l1_req_address),
    .l1_req_type           (l1_req_type),
    .l1_req_valid          (l1_req_valid),
    .l1_word_to_store      (l1_word_to_store),
    .l1_fetched_word       (l1_fetched_word),
    .l1_fetched_word_valid (l1_fetched_word_valid),
    .mem_req_address       (mem_req_address),
    .mem_req_type          (mem_req_type),
    .mem_req_valid         (mem_req_valid),
    .mem_word_to_store     (mem_word_to_store),
    .mem_fetched_word      (mem_fetched_word),
    .mem_req_fulfilled     (mem_ack | spur_ack),
    .debug_state           (debug_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    l1_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // backing memory: fulfilled is sampled on the MEM_L-th edge that sees valid
  function automatic logic [31:0] backing_word(input logic [31:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    if (a[31:4] == 28'h0000188) return 32'h11110000 + {30'd0, a[3:2]};
    return a ^ 32'hA5A5A5A5;
  endfunction

  always @(negedge clk) begin
    if (reset && mem_req_valid && !mem_ack) begin
      mem_wait++;
      if (mem_wait == MEM_L) begin
        mem_ack = 1'b1;
        mem_addr_q.push_back(mem_req_address);
        mem_type_q.push_back(mem_req_type);
        if (mem_req_type == STORE) begin
          mem_store[mem_req_address] = mem_word_to_store;
          mem_data_q.push_back(mem_word_to_store);
          mem_fetched_word = '0;
        end else begin
          mem_fetched_word = backing_word(mem_req_address);
          mem_data_q.push_back(mem_fetched_word);
        end
      end
    end else begin
      mem_ack = 1'b0;
      mem_wait = 0;
    end
  end

  // drivers
  task automatic clear_log();
    mem_addr_q.delete();
    mem_data_q.delete();
    mem_type_q.delete();
  endtask

  // lat counts edges from acceptance to the edge that first samples completion;
  // -1 means no completion, -2 means completion never released.
  task automatic do_req(input memory_operation_e t, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] word, output int lat);
    int n;
    @(negedge clk);
    l1_req_type = t;
    l1_req_address = a;
    l1_word_to_store = d;
    l1_req_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!l1_fetched_word_valid && n < TIMEOUT);
    word = l1_fetched_word;
    lat = l1_fetched_word_valid ? n : -1;
    l1_req_valid = 1'b0;
    l1_req_address = $urandom;
    n = 0;
    do begin @(negedge clk); n++; end while (l1_fetched_word_valid && n < TIMEOUT);
    if (l1_fetched_word_valid) lat = -2;
  endtask

  // scenarios
  task automatic test_reset();
    logic [98:0] outs;
    l1_req_valid = 1'b0;
    l1_req_type = LOAD;
    l1_req_address = '0;
    l1_word_to_store = '0;
    spur_ack = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    outs = {l1_fetched_word_valid, l1_fetched_word, mem_req_valid, mem_req_address,
            mem_word_to_store, mem_req_type};
    checks++;
    if (outs !== '0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", outs);
    end
    checks++;
    if (debug_state !== 3'd0) begin
      failures++; $display("FAIL reset_state got=%0d exp=0", debug_state);
    end
    reset = 1'b1;
  endtask

  task automatic test_cold_miss();
    logic [31:0] w;
    int lat;
    clear_log();
    do_req(LOAD, 32'h0000188C, 32'h0, w, lat);
    checks++;
    if (w !== 32'h11110003) begin failures++; $display("FAIL cold_word got=%h exp=11110003", w); end
    checks++;
    if (lat !== 19) begin failures++; $display("FAIL cold_latency got=%0d exp=19", lat); end
    checks++;
    if (mem_addr_q.size() !== 4) begin
      failures++; $display("FAIL cold_mem_count got=%0d exp=4", mem_addr_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (mem_addr_q[i] !== 32'h1880 + 32'(4 * i) || mem_type_q[i] !== LOAD) begin
          failures++;
          $display("FAIL cold_fill_addr[%0d] got=%h/%0d exp=%h/LOAD", i, mem_addr_q[i],
                   mem_type_q[i], 32'h1880 + 32'(4 * i));
        end
      end
    end
  endtask

  task automatic test_hit();
    logic [31:0] w;
    int lat;
    clear_log();
    do_req(LOAD, 32'h00001884, 32'h0, w, lat);
    checks++;
    if (w !== 32'h11110001) begin failures++; $display("FAIL hit_word got=%h exp=11110001", w); end
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL hit_latency got=%0d exp=2", lat); end
    checks++;
    if (mem_addr_q.size() !== 0) begin
      failures++; $display("FAIL hit_mem_count got=%0d exp=0", mem_addr_q.size());
    end
  endtask

  task automatic test_store_hit();
    logic [31:0] w;
    int lat;
    clear_log();
    do_req(STORE, 32'h00001888, 32'hDEADBEEF, w, lat);
    checks++;
    if (lat < 0) begin failures++; $display("FAIL store_hit_done got=%0d exp=>0", lat); end
    checks++;
    if (w !== 32'h0) begin failures++; $display("FAIL store_hit_l1_word got=%h exp=0", w); end
    checks++;
    if (mem_addr_q.size() !== 1) begin
      failures++; $display("FAIL store_hit_mem_count got=%0d exp=1", mem_addr_q.size());
    end else begin
      checks++;
      if (mem_addr_q[0] !== 32'h1888 || mem_type_q[0] !== STORE || mem_data_q[0] !== 32'hDEADBEEF) begin
        failures++;
        $display("FAIL store_hit_mem got=%h/%0d/%h exp=00001888/STORE/deadbeef",
                 mem_addr_q[0], mem_type_q[0], mem_data_q[0]);
      end
    end
    clear_log();
    do_req(LOAD, 32'h00001888, 32'h0, w, lat);
    checks++;
    if (w !== 32'hDEADBEEF) begin failures++; $display("FAIL store_hit_readback got=%h exp=deadbeef", w); end
    checks++;
    if (lat !== 2 || mem_addr_q.size() !== 0) begin
      failures++;
      $display("FAIL store_hit_readback_hit got=lat%0d/mem%0d exp=lat2/mem0", lat, mem_addr_q.size());
    end
  endtask

  task automatic test_store_miss();
    logic [31:0] w;
    int lat;
    clear_log();
    do_req(STORE, 32'hBEEF67BA, 32'hCAFEF00D, w, lat);
    checks++;
    if (mem_addr_q.size() !== 1) begin
      failures++; $display("FAIL store_miss_mem_count got=%0d exp=1", mem_addr_q.size());
    end else begin
      checks++;
      if (mem_addr_q[0] !== 32'hBEEF67B8 || mem_type_q[0] !== STORE || mem_data_q[0] !== 32'hCAFEF00D) begin
        failures++;
        $display("FAIL store_miss_mem got=%h/%0d/%h exp=beef67b8/STORE/cafef00d",
                 mem_addr_q[0], mem_type_q[0], mem_data_q[0]);
      end
    end
    clear_log();
    do_req(LOAD, 32'hBEEF67BA, 32'h0, w, lat);
    checks++;
    if (lat !== 19 || mem_addr_q.size() !== 4) begin
      failures++;
      $display("FAIL store_miss_no_alloc got=lat%0d/mem%0d exp=lat19/mem4", lat, mem_addr_q.size());
    end
    checks++;
    if (mem_addr_q.size() < 1 || mem_addr_q[0] !== 32'hBEEF67B0) begin
      failures++; $display("FAIL store_miss_fill_start got=%h exp=beef67b0",
                           (mem_addr_q.size() > 0) ? mem_addr_q[0] : 32'hX);
    end
    checks++;
    if (w !== 32'hCAFEF00D) begin failures++; $display("FAIL store_miss_load_word got=%h exp=cafef00d", w); end
  endtask

  task automatic test_eviction();
    logic [31:0] addrs [3];
    logic [31:0] exps [3];
    logic [31:0] w;
    int lat;
    addrs = '{32'h00001880, 32'h00002880, 32'h00001880};
    exps  = '{32'h11110000, 32'hA5A58D25, 32'h11110000};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      clear_log();
      do_req(LOAD, addrs[i], 32'h0, w, lat);
      checks++;
      if (w !== exps[i] || lat !== 19) begin
        failures++; $display("FAIL evict_load[%0d] got=%h/lat%0d exp=%h/lat19", i, w, lat, exps[i]);
      end
      checks++;
      if (mem_addr_q.size() !== 4 || mem_addr_q[0] !== addrs[i]) begin
        failures++; $display("FAIL evict_fill[%0d] got=mem%0d exp=mem4 from %h", i, mem_addr_q.size(), addrs[i]);
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [98:0] outs;
    logic [31:0] w;
    int lat;
    int n;
    apply_reset();
    clear_log();
    @(negedge clk);
    l1_req_type = LOAD;
    l1_req_address = 32'h0000188C;
    l1_req_valid = 1'b1;
    n = 0;
    while (mem_addr_q.size() < 2 && n < TIMEOUT) begin @(negedge clk); n++; end
    while (mem_req_valid && n < TIMEOUT) begin @(negedge clk); n++; end
    while (!mem_req_valid && n < TIMEOUT) begin @(negedge clk); n++; end
    checks++;
    if (n >= TIMEOUT || mem_req_address !== 32'h1888) begin
      failures++; $display("FAIL midfill_reach_word2 got=%h exp=00001888", mem_req_address);
    end
    reset = 1'b0;
    l1_req_valid = 1'b0;
    @(negedge clk);
    outs = {l1_fetched_word_valid, l1_fetched_word, mem_req_valid, mem_req_address,
            mem_word_to_store, mem_req_type};
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL midfill_reset_outputs got=%h exp=0", outs); end
    reset = 1'b1;
    @(negedge clk);
    clear_log();
    do_req(LOAD, 32'h0000188C, 32'h0, w, lat);
    checks++;
    if (w !== 32'h11110003 || lat !== 19) begin
      failures++; $display("FAIL midfill_reload got=%h/lat%0d exp=11110003/lat19", w, lat);
    end
    checks++;
    if (mem_addr_q.size() !== 4 || mem_addr_q[0] !== 32'h1880) begin
      failures++; $display("FAIL midfill_refill got=mem%0d exp=mem4 from 00001880", mem_addr_q.size());
    end
  endtask

  task automatic test_latched_request();
    int n;
    clear_log();
    @(negedge clk);
    spur_ack = 1'b1;
    @(negedge clk);
    spur_ack = 1'b0;
    l1_req_type = LOAD;
    l1_req_address = 32'h00001884;
    l1_req_valid = 1'b1;
    @(negedge clk);
    l1_req_type = STORE;
    l1_req_address = 32'h0000188C;
    l1_word_to_store = 32'h0BAD0BAD;
    n = 1;
    while (!l1_fetched_word_valid && n < TIMEOUT) begin @(negedge clk); n++; end
    checks++;
    if (l1_fetched_word !== 32'h11110001 || n !== 2) begin
      failures++; $display("FAIL latched_word got=%h/lat%0d exp=11110001/lat2", l1_fetched_word, n);
    end
    @(negedge clk);
    checks++;
    if (l1_fetched_word_valid !== 1'b1) begin
      failures++; $display("FAIL respond_hold got=%b exp=1", l1_fetched_word_valid);
    end
    l1_req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (l1_fetched_word_valid && n < TIMEOUT);
    checks++;
    if (n !== 1 || mem_addr_q.size() !== 0) begin
      failures++; $display("FAIL latched_release got=cyc%0d/mem%0d exp=cyc1/mem0", n, mem_addr_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] exps [3];
    logic [31:0] w;
    int lat;
    addrs = '{32'h00001880, 32'h00001888, 32'h0000188C};
    exps  = '{32'h11110000, 32'hDEADBEEF, 32'h11110003};
    clear_log();
    for (int i = 0; i < 3; i++) begin
      do_req(LOAD, addrs[i], 32'h0, w, lat);
      checks++;
      if (w !== exps[i] || lat !== 2) begin
        failures++; $display("FAIL b2b_hit[%0d] got=%h/lat%0d exp=%h/lat2", i, w, lat, exps[i]);
      end
    end
    checks++;
    if (mem_addr_q.size() !== 0) begin
      failures++; $display("FAIL b2b_mem_count got=%0d exp=0", mem_addr_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_store_hit();
    test_store_miss();
    test_eviction();
    test_reset_mid_fill();
    test_latched_request();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
